remover_seg_ctrl: RTL and testbench

- Per-packet controller placed in front of the dynamic segment remover datapath.
- Buffers the leading beats of each AXI-Stream packet until the 16-bit tag field at a fixed byte offset has been seen.
- From that field it decides the removal size: MAX_REMOVE_BYTES or 0.
- Releases the packet downstream with seg_size held stable from the packet's first output beat through its tlast handshake.

---
 rtl/remover_pkg.sv | 28 ++
 rtl/remover_seg_ctrl_hdr_beat_buf.sv | 61 ++++++
 rtl/remover_seg_ctrl.sv | 133 +++++++++++++
 tb/tb_remover_seg_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/remover_pkg.sv
// Shared types and elaboration-time helpers for the segment remover controller.
package remover_pkg;

  localparam logic [15:0] DEFAULT_TAG_MATCH = 16'h8100;

  typedef enum logic [1:0] {
    COLLECT,
    DRAIN,
    PASS
  } state_e;

  function automatic int unsigned seg_w(input int unsigned max_remove_bytes);
    return $clog2(max_remove_bytes + 1);
  endfunction

  function automatic int unsigned field_beat(input int unsigned offset, input int unsigned bytes);
    return offset / bytes;
  endfunction

  function automatic int unsigned hdr_beats(input int unsigned offset, input int unsigned bytes);
    return field_beat(offset, bytes) + 1;
  endfunction

  function automatic int unsigned field_lane(input int unsigned offset, input int unsigned bytes);
    return offset % bytes;
  endfunction

endpackage

// File: rtl/remover_seg_ctrl_hdr_beat_buf.sv
// Small synchronous FIFO holding the leading beats of a packet until the decision is made.
module hdr_beat_buf #(
  parameter int unsigned DW    = 64,
  parameter int unsigned KW    = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned LW   = $clog2(DEPTH + 1),
  localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic [KW-1:0] wr_keep,
  input  logic          wr_last,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic [KW-1:0] rd_keep,
  output logic          rd_last,
  output logic          empty,
  output logic          full,
  output logic [LW-1:0] level
);

  logic [DW-1:0] mem_data [DEPTH];
  logic [KW-1:0] mem_keep [DEPTH];
  logic          mem_last [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  assign empty = (level == '0);
  assign full  = (level == LW'(DEPTH));
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  assign rd_data = mem_data[rd_ptr];
  assign rd_keep = mem_keep[rd_ptr];
  assign rd_last = mem_last[rd_ptr];

  always_ff @(posedge aclk) begin
    if (do_wr) begin
      mem_data[wr_ptr] <= wr_data;
      mem_keep[wr_ptr] <= wr_keep;
      mem_last[wr_ptr] <= wr_last;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_wr) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      level <= level + LW'(do_wr) - LW'(do_rd);
    end
  end

endmodule

// File: rtl/remover_seg_ctrl.sv
// Per-packet controller: holds header beats until the tag field is seen, fixes seg_size, then releases.
module remover_seg_ctrl
  import remover_pkg::*;
#(
  parameter int unsigned AXIS_BUS_WIDTH   = 64,
  parameter int unsigned MAX_REMOVE_BYTES = 4,
  parameter int unsigned TAG_FIELD_OFFSET = 12,
  parameter logic [15:0] TAG_MATCH        = DEFAULT_TAG_MATCH,
  localparam int unsigned BYTES           = AXIS_BUS_WIDTH / 8,
  localparam int unsigned SEG_W           = seg_w(MAX_REMOVE_BYTES)
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      cfg_enable,
  input  logic [AXIS_BUS_WIDTH-1:0] s_tdata,
  input  logic [BYTES-1:0]          s_tkeep,
  input  logic                      s_tlast,
  input  logic                      s_tvalid,
  output logic                      s_tready,
  output logic [AXIS_BUS_WIDTH-1:0] m_tdata,
  output logic [BYTES-1:0]          m_tkeep,
  output logic                      m_tlast,
  output logic                      m_tvalid,
  input  logic                      m_tready,
  output logic [SEG_W-1:0]          seg_size,
  output logic [31:0]               rmv_pkt_count
);

  localparam int unsigned FIELD_BEAT = field_beat(TAG_FIELD_OFFSET, BYTES);
  localparam int unsigned HDR_BEATS  = hdr_beats(TAG_FIELD_OFFSET, BYTES);
  localparam int unsigned FIELD_LANE = field_lane(TAG_FIELD_OFFSET, BYTES);
  localparam int unsigned LW         = $clog2(HDR_BEATS + 1);

  state_e                      state, state_nxt;
  logic                        rdy_en;
  logic [LW-1:0]               beat_cnt;
  logic                        en_cap;
  logic                        buf_wr, buf_rd, buf_empty, buf_full;
  logic [AXIS_BUS_WIDTH-1:0]   buf_data;
  logic [BYTES-1:0]            buf_keep;
  logic                        buf_last;
  logic [LW-1:0]               buf_level;
  logic                        at_field, en_eff, keep_ok, hit;
  logic [15:0]                 field;

  hdr_beat_buf #(
    .DW    (AXIS_BUS_WIDTH),
    .KW    (BYTES),
    .DEPTH (HDR_BEATS)
  ) u_buf (
    .aclk    (aclk),
    .aresetn (aresetn),
    .wr_en   (buf_wr),
    .wr_data (s_tdata),
    .wr_keep (s_tkeep),
    .wr_last (s_tlast),
    .rd_en   (buf_rd),
    .rd_data (buf_data),
    .rd_keep (buf_keep),
    .rd_last (buf_last),
    .empty   (buf_empty),
    .full    (buf_full),
    .level   (buf_level)
  );

  // Byte FIELD_LANE is first on the wire, so it forms the high byte of the field.
  assign field    = {s_tdata[8*FIELD_LANE +: 8], s_tdata[8*(FIELD_LANE+1) +: 8]};
  assign keep_ok  = s_tkeep[FIELD_LANE] && s_tkeep[FIELD_LANE+1];
  assign at_field = (beat_cnt == LW'(FIELD_BEAT));
  assign en_eff   = (beat_cnt == '0) ? cfg_enable : en_cap;
  assign hit      = at_field && en_eff && keep_ok && (field == TAG_MATCH);

  always_comb begin
    state_nxt = state;
    s_tready  = 1'b0;
    m_tvalid  = 1'b0;
    m_tdata   = buf_data;
    m_tkeep   = buf_keep;
    m_tlast   = buf_last;
    buf_wr    = 1'b0;
    buf_rd    = 1'b0;
    case (state)
      COLLECT: begin
        s_tready = rdy_en && !buf_full;
        buf_wr   = s_tvalid && s_tready;
        if (buf_wr && (at_field || s_tlast)) state_nxt = DRAIN;
      end
      DRAIN: begin
        m_tvalid = !buf_empty;
        buf_rd   = m_tvalid && m_tready;
        if (buf_rd) begin
          if (buf_last) state_nxt = COLLECT;
          else if (buf_level == LW'(1)) state_nxt = PASS;
        end
      end
      PASS: begin
        m_tdata  = s_tdata;
        m_tkeep  = s_tkeep;
        m_tlast  = s_tlast;
        m_tvalid = s_tvalid;
        s_tready = m_tready;
        if (s_tvalid && m_tready && s_tlast) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state         <= COLLECT;
      rdy_en        <= 1'b0;
      beat_cnt      <= '0;
      en_cap        <= 1'b0;
      seg_size      <= '0;
      rmv_pkt_count <= '0;
    end else begin
      state  <= state_nxt;
      rdy_en <= 1'b1;
      if (buf_wr) begin
        if (beat_cnt == '0) en_cap <= cfg_enable;
        if (at_field || s_tlast) begin
          beat_cnt <= '0;
          seg_size <= hit ? SEG_W'(MAX_REMOVE_BYTES) : '0;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
      if (m_tvalid && m_tready && m_tlast && (seg_size != '0) && (rmv_pkt_count != '1))
        rmv_pkt_count <= rmv_pkt_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_remover_seg_ctrl.sv
// Directed bench for remover_seg_ctrl at default parameters (64-bit bus, tag at byte 12).
module tb_remover_seg_ctrl;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        cfg_enable;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic        s_tlast;
  logic        s_tvalid;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [2:0]  seg_size;
  logic [31:0] rmv_pkt_count;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [2:0]  s;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  localparam logic [63:0] TAGGED   = 64'hA5A5_0081_A5A5_A5A5;
  localparam logic [63:0] UNTAGGED = 64'hA5A5_0008_A5A5_A5A5;

  always #5 aclk = ~aclk;

  remover_seg_ctrl #(
    .AXIS_BUS_WIDTH   (64),
    .MAX_REMOVE_BYTES (4),
    .TAG_FIELD_OFFSET (12),
    .TAG_MATCH        (16'h8100)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_enable    (cfg_enable),
    .s_tdata       (s_tdata),
    .s_tkeep       (s_tkeep),
    .s_tlast       (s_tlast),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .m_tdata       (m_tdata),
    .m_tkeep       (m_tkeep),
    .m_tlast       (m_tlast),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .seg_size      (seg_size),
    .rmv_pkt_count (rmv_pkt_count)
  );

  // Output monitor: records every beat that will hand off at the next rising edge.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready)
      got_q.push_back('{d: m_tdata, k: m_tkeep, l: m_tlast, s: seg_size});
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic en);
    int unsigned n = 0;
    s_tdata    = d;
    s_tkeep    = k;
    s_tlast    = l;
    cfg_enable = en;
    s_tvalid   = 1'b1;
    @(negedge aclk);
    while (!s_tready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    check("s_handshake", 64'(n < 100), 64'd1);
    cycle();
    s_tvalid = 1'b0;
  endtask

  task automatic expect_beat(input logic [63:0] d, input logic [7:0] k, input logic l, input logic [2:0] s);
    exp_q.push_back('{d: d, k: k, l: l, s: s});
  endtask

  // Three-beat packet; beat1 carries the tag field in bytes 4,5.
  task automatic send_pkt3(input string tag, input logic [63:0] base, input logic [63:0] b1,
                           input logic [7:0] k1, input logic en0, input logic en1,
                           input logic [2:0] exp_seg);
    expect_beat(base, 8'hFF, 1'b0, exp_seg);
    expect_beat(b1, k1, 1'b0, exp_seg);
    expect_beat(~base, 8'h3F, 1'b1, exp_seg);
    send_beat(base, 8'hFF, 1'b0, en0);
    send_beat(b1, k1, 1'b0, en1);
    check({tag, "_first_valid"}, 64'(m_tvalid), 64'd1);
    check({tag, "_seg_at_first"}, 64'(seg_size), 64'(exp_seg));
    check({tag, "_drain_no_ready"}, 64'(s_tready), 64'd0);
    send_beat(~base, 8'h3F, 1'b1, en1);
  endtask

  task automatic drain_check(input string tag);
    int unsigned n = 0;
    while (got_q.size() < exp_q.size() && n < 100) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    check({tag, "_nbeats"}, 64'(got_q.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      beat_t e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_data"}, g.d, e.d);
      check({tag, "_keep"}, 64'(g.k), 64'(e.k));
      check({tag, "_last"}, 64'(g.l), 64'(e.l));
      check({tag, "_seg"}, 64'(g.s), 64'(e.s));
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] pat;
    pat        = 4'b1001;
    aresetn    = 1'b0;
    cfg_enable = 1'b0;
    s_tdata    = '0;
    s_tkeep    = '0;
    s_tlast    = 1'b0;
    s_tvalid   = 1'b0;
    m_tready   = 1'b1;
    repeat (3) cycle();
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_seg", 64'(seg_size), 64'd0);
    check("rst_count", rmv_pkt_count, 64'd0);
    aresetn = 1'b1;
    cycle();
    check("ready_after_rst", 64'(s_tready), 64'd1);

    send_pkt3("tagged", 64'h0706_0504_0302_0100, TAGGED, 8'hFF, 1'b1, 1'b1, 3'd4);
    drain_check("tagged");
    check("tagged_count", rmv_pkt_count, 64'd1);

    expect_beat(64'hDEAD_BEEF_0000_1234, 8'h0F, 1'b1, 3'd0);
    send_beat(64'hDEAD_BEEF_0000_1234, 8'h0F, 1'b1, 1'b1);
    check("short_latency", 64'(m_tvalid), 64'd1);
    check("short_seg", 64'(seg_size), 64'd0);
    drain_check("short");
    check("short_count", rmv_pkt_count, 64'd1);

    send_pkt3("untagged", 64'h1111_2222_3333_4444, UNTAGGED, 8'hFF, 1'b1, 1'b1, 3'd0);
    drain_check("untagged");
    check("untagged_count", rmv_pkt_count, 64'd1);

    fork
      begin
        send_pkt3("bp_tagged", 64'h5555_6666_7777_8888, TAGGED, 8'hFF, 1'b1, 1'b1, 3'd4);
        send_pkt3("bp_untagged", 64'h9999_AAAA_BBBB_CCCC, UNTAGGED, 8'hFF, 1'b1, 1'b1, 3'd0);
      end
      begin
        for (int i = 0; i < 30; i++) begin
          m_tready = pat[i % 4];
          cycle();
        end
        m_tready = 1'b1;
      end
    join
    drain_check("bp");
    check("bp_count", rmv_pkt_count, 64'd2);

    send_pkt3("tagged2", 64'h0123_4567_89AB_CDEF, TAGGED, 8'hFF, 1'b1, 1'b1, 3'd4);
    drain_check("tagged2");
    send_pkt3("disabled", 64'hFEDC_BA98_7654_3210, TAGGED, 8'hFF, 1'b0, 1'b1, 3'd0);
    drain_check("disabled");
    check("disabled_count", rmv_pkt_count, 64'd3);

    send_pkt3("tagged3", 64'h0F0F_0F0F_0F0F_0F0F, TAGGED, 8'hFF, 1'b1, 1'b1, 3'd4);
    drain_check("tagged3");
    send_pkt3("keep_off", 64'hF0F0_F0F0_F0F0_F0F0, TAGGED, 8'hCF, 1'b1, 1'b1, 3'd0);
    drain_check("keep_off");
    check("keep_off_count", rmv_pkt_count, 64'd4);

    expect_beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0, 3'd4);
    expect_beat(TAGGED, 8'hFF, 1'b0, 3'd4);
    send_beat(64'h1234_5678_9ABC_DEF0, 8'hFF, 1'b0, 1'b1);
    send_beat(TAGGED, 8'hFF, 1'b0, 1'b1);
    s_tdata  = 64'h0BAD_0BAD_0BAD_0BAD;
    s_tkeep  = 8'hFF;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    cycle();
    cycle();
    check("pass_m_tvalid", 64'(m_tvalid), 64'd1);
    check("pass_m_tdata", m_tdata, 64'h0BAD_0BAD_0BAD_0BAD);
    check("pass_s_tready", 64'(s_tready), 64'd1);
    aresetn = 1'b0;
    cycle();
    aresetn  = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_seg", 64'(seg_size), 64'd0);
    check("midrst_count", rmv_pkt_count, 64'd0);
    drain_check("midrst");

    send_pkt3("post_rst", 64'h7777_0000_7777_0000, TAGGED, 8'hFF, 1'b1, 1'b1, 3'd4);
    drain_check("post_rst");
    check("post_rst_count", rmv_pkt_count, 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
